// File: rtl/systolic_feeder.sv
// Front end for systolic_array: streams a weight load, then skews activation rows
// into the array, flushes it, and pulses done once the flush completes.
module systolic_feeder #(
   parameter int ROWS        = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int SKEW        = 2,
   parameter int DRAIN_EXTRA = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         w_valid,
   output logic                         w_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]   w_data,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [ROWS*DATA_WIDTH-1:0]   a_data,
   input  logic                         a_last,
   output logic [ROWS*DATA_WIDTH-1:0]   pixel_in_bus,
   output logic                         load_W,
   output logic                         enable_cycle,
   output logic                         busy,
   output logic                         done
);

   localparam int DRAIN_LEN = (ROWS - 1) * SKEW + DRAIN_EXTRA;
   localparam int WCW       = $clog2(ROWS + 1);
   localparam int DCW       = (DRAIN_LEN < 2) ? 1 : $clog2(DRAIN_LEN + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t                       state, next_state;
   logic [WCW-1:0]               wcnt;
   logic [DCW-1:0]               dcnt;
   logic                         w_fire, a_fire;
   logic [ROWS*DATA_WIDTH-1:0]   skew_in, skew_tap;

   assign w_fire  = w_valid && w_ready;
   assign a_fire  = a_valid && a_ready;
   assign skew_in = a_fire ? a_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (w_fire) next_state = LOAD;
         LOAD:  if (w_fire && wcnt == WCW'(ROWS - 1)) next_state = RUN;
         RUN:   if (a_fire && a_last) next_state = DRAIN;
         DRAIN: if (dcnt <= DCW'(1)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt <= '0;
         dcnt <= '0;
      end else begin
         if (w_fire) wcnt <= (state == IDLE) ? WCW'(1) : wcnt + 1'b1;
         if (state == RUN && a_fire && a_last) dcnt <= DCW'(DRAIN_LEN);
         else if (state == DRAIN && dcnt != '0) dcnt <= dcnt - 1'b1;
      end
   end

   // Lane r gets r*SKEW delay stages ahead of the shared output register.
   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      localparam int DEPTH = r * SKEW;
      if (DEPTH == 0) begin : g_direct
         assign skew_tap[r*DATA_WIDTH +: DATA_WIDTH] = skew_in[r*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] line [DEPTH];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) line[k] <= '0;
            end else begin
               line[0] <= skew_in[r*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
            end
         end
         assign skew_tap[r*DATA_WIDTH +: DATA_WIDTH] = line[DEPTH-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_ready      <= 1'b0;
         a_ready      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         load_W       <= 1'b0;
         enable_cycle <= 1'b0;
         pixel_in_bus <= '0;
      end else begin
         w_ready      <= (next_state == IDLE) || (next_state == LOAD);
         a_ready      <= (next_state == RUN);
         busy         <= (next_state != IDLE);
         done         <= (state == DRAIN) && (next_state == IDLE);
         load_W       <= w_fire;
         enable_cycle <= w_fire || (next_state == RUN) || (next_state == DRAIN);
         if (w_fire)
            pixel_in_bus <= w_data;
         else if (next_state == RUN || next_state == DRAIN)
            pixel_in_bus <= skew_tap;
         else
            pixel_in_bus <= '0;
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: weight load, skewed activations, bubbles,
// drain/done timing and reset in mid-run.
module tb_systolic_feeder;

   localparam int ROWS   = 8;
   localparam int DW     = 8;
   localparam int SKEW   = 2;
   localparam int DEXTRA = 10;
   localparam int BUS    = ROWS * DW;
   localparam int DLEN   = (ROWS - 1) * SKEW + DEXTRA;

   logic           clk = 1'b0;
   logic           rst;
   logic           w_valid, w_ready;
   logic [BUS-1:0] w_data;
   logic           a_valid, a_ready;
   logic [BUS-1:0] a_data;
   logic           a_last;
   logic [BUS-1:0] pixel_in_bus;
   logic           load_W, enable_cycle, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   systolic_feeder #(
      .ROWS(ROWS), .DATA_WIDTH(DW), .SKEW(SKEW), .DRAIN_EXTRA(DEXTRA)
   ) dut (
      .clk(clk), .rst(rst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
      .pixel_in_bus(pixel_in_bus), .load_W(load_W), .enable_cycle(enable_cycle),
      .busy(busy), .done(done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [BUS+5:0] all_out;
      rst = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      #3 rst = 1'b1;
      #1;
      all_out = {w_ready, a_ready, busy, done, load_W, enable_cycle, pixel_in_bus};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%h exp=0", all_out);
      end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if ({w_ready, a_ready, busy, done} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL reset_release got=%b exp=1000", {w_ready, a_ready, busy, done});
      end
      // Activations offered in IDLE must not be taken.
      a_valid = 1'b1; a_data = {ROWS{8'h55}};
      step();
      checks++;
      if ({a_ready, busy, enable_cycle, pixel_in_bus} !== '0) begin
         errors++;
         $display("[TB] FAIL idle_ignores_a got=%h exp=0", {a_ready, busy, enable_cycle, pixel_in_bus});
      end
      a_valid = 1'b0; a_data = '0;
      #($urandom_range(1, 8)) rst = 1'b1;
      #1;
      all_out = {w_ready, a_ready, busy, done, load_W, enable_cycle, pixel_in_bus};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL reset_random got=%h exp=0", all_out);
      end
      step();
      rst = 1'b0;
      step();
      checks++;
      if ({w_ready, a_ready, busy} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_random_release got=%b exp=100", {w_ready, a_ready, busy});
      end
   endtask

   task automatic test_weight_load(input logic [DW-1:0] v);
      logic [BUS+3:0] exp;
      for (int i = 0; i < ROWS; i++) begin
         w_valid = 1'b1; w_data = {ROWS{v}};
         step();
         exp = {1'b1, 1'b1, (i < ROWS-1), (i == ROWS-1), {ROWS{v}}};
         checks++;
         if ({load_W, enable_cycle, w_ready, a_ready, pixel_in_bus} !== exp) begin
            errors++;
            $display("[TB] FAIL weight_beat%0d got=%h exp=%h", i,
                     {load_W, enable_cycle, w_ready, a_ready, pixel_in_bus}, exp);
         end
      end
      w_valid = 1'b0; w_data = '0;
      step();
      checks++;
      if ({load_W, enable_cycle, busy, pixel_in_bus} !== {3'b011, {BUS{1'b0}}}) begin
         errors++;
         $display("[TB] FAIL run_idle_cycle got=%h exp=%h",
                  {load_W, enable_cycle, busy, pixel_in_bus}, {3'b011, {BUS{1'b0}}});
      end
   endtask

   task automatic test_single_activation();
      logic [BUS-1:0] exp;
      int sum = 0;
      a_valid = 1'b1; a_data = {ROWS{8'd5}}; a_last = 1'b1;
      step();
      a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      for (int k = 1; k <= DLEN; k++) begin
         exp = '0;
         for (int r = 0; r < ROWS; r++)
            if (k == 1 + r*SKEW) exp[r*DW +: DW] = 8'd5;
         checks++;
         if ({busy, done, enable_cycle, a_ready, pixel_in_bus} !== {4'b1010, exp}) begin
            errors++;
            $display("[TB] FAIL single_drain_c%0d got=%h exp=%h", k,
                     {busy, done, enable_cycle, a_ready, pixel_in_bus}, {4'b1010, exp});
         end
         for (int r = 0; r < 4; r++) sum += 2 * int'(pixel_in_bus[r*DW +: DW]);
         step();
      end
      checks++;
      if ({busy, done, enable_cycle, w_ready, pixel_in_bus} !== {4'b0101, {BUS{1'b0}}}) begin
         errors++;
         $display("[TB] FAIL single_done got=%h exp=%h",
                  {busy, done, enable_cycle, w_ready, pixel_in_bus}, {4'b0101, {BUS{1'b0}}});
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL done_one_cycle got=%b exp=0", done);
      end
      checks++;
      if (sum != 40) begin
         errors++;
         $display("[TB] FAIL array_sum got=%0d exp=40", sum);
      end
   endtask

   task automatic test_gapped_weights();
      int acc = 0;
      logic pat;
      logic [DW-1:0] v;
      logic [BUS+2:0] exp;
      for (int i = 0; i < 40 && acc < ROWS; i++) begin
         pat = (i % 5 == 0) || (i % 5 == 2) || (i % 5 == 3);
         v = 8'h10 + 8'(acc);
         w_valid = pat;
         w_data = pat ? {ROWS{v}} : {ROWS{8'hEE}};
         step();
         if (pat) acc++;
         exp = pat ? {2'b11, (acc == ROWS), {ROWS{v}}} : {3'b000, {BUS{1'b0}}};
         checks++;
         if ({load_W, enable_cycle, a_ready, pixel_in_bus} !== exp) begin
            errors++;
            $display("[TB] FAIL gapped_c%0d got=%h exp=%h", i,
                     {load_W, enable_cycle, a_ready, pixel_in_bus}, exp);
         end
      end
      w_valid = 1'b0; w_data = '0;
      step();
      checks++;
      if ({w_ready, a_ready, load_W, enable_cycle} !== 4'b0101) begin
         errors++;
         $display("[TB] FAIL gapped_run got=%b exp=0101", {w_ready, a_ready, load_W, enable_cycle});
      end
   endtask

   task automatic test_activation_bubbles();
      logic [BUS-1:0] exp;
      int n = 0;
      for (int k = 0; k < 18; k++) begin
         a_last = 1'b0; a_valid = 1'b0; a_data = {ROWS{8'hAA}};
         if (k == 0) begin a_valid = 1'b1; a_data = {ROWS{8'd10}}; end
         if (k == 2) begin a_valid = 1'b1; a_data = {ROWS{8'd3}}; a_last = 1'b1; end
         // Offered during DRAIN, where it must be ignored.
         if (k == 4) begin a_valid = 1'b1; a_data = {ROWS{8'h77}}; end
         step();
         exp = '0;
         for (int r = 0; r < ROWS; r++) begin
            if (k + 1 == 1 + r*SKEW) exp[r*DW +: DW] = 8'd10;
            if (k + 1 == 3 + r*SKEW) exp[r*DW +: DW] = 8'd3;
         end
         checks++;
         if ({enable_cycle, busy, pixel_in_bus} !== {2'b11, exp}) begin
            errors++;
            $display("[TB] FAIL bubble_c%0d got=%h exp=%h", k + 1,
                     {enable_cycle, busy, pixel_in_bus}, {2'b11, exp});
         end
      end
      a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n != 9 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bubble_done_wait got=%0d busy=%b exp=9 busy=0", n, busy);
      end
   endtask

   task automatic test_reset_during_run();
      logic [BUS+5:0] all_out;
      test_weight_load(8'h01);
      a_valid = 1'b1; a_data = {ROWS{8'd7}}; a_last = 1'b0;
      step();
      a_valid = 1'b0; a_data = '0;
      step();
      #2 rst = 1'b1;
      #1;
      all_out = {w_ready, a_ready, busy, done, load_W, enable_cycle, pixel_in_bus};
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_reset got=%h exp=0", all_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step();
         checks++;
         if ({done, busy, w_ready, enable_cycle, pixel_in_bus} !== {4'b0010, {BUS{1'b0}}}) begin
            errors++;
            $display("[TB] FAIL post_reset_c%0d got=%h exp=%h", k,
                     {done, busy, w_ready, enable_cycle, pixel_in_bus}, {4'b0010, {BUS{1'b0}}});
         end
      end
      test_weight_load(8'h03);
      test_single_activation();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      test_reset();
      test_weight_load(8'h02);
      test_single_activation();
      test_gapped_weights();
      test_activation_bubbles();
      test_reset_during_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
